// File: rtl/pe_array_ctrl.sv
// Job sequencer for the PE array: issues weight/activation buffer reads, aligns the
// clear/mac strobes to the PE pipeline and holds the result under a valid/ready handshake.
module pe_array_ctrl #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [ADDR_W-1:0] cfg_wet_base,
    input  logic [ADDR_W-1:0] cfg_act_base,
    input  logic [7:0]        cfg_shift,
    output logic              busy,
    output logic              wet_rd_en,
    output logic [ADDR_W-1:0] wet_rd_addr,
    output logic              act_rd_en,
    output logic [ADDR_W-1:0] act_rd_addr,
    output logic              pe_mac_en,
    output logic              pe_clear_acc,
    output logic [7:0]        pe_shift_num,
    output logic              res_valid,
    input  logic              res_ready
);

    // Three spare bits cover K + RD_LAT + 2 for the largest K and RD_LAT up to 3.
    localparam int CNT_W = LEN_W + 3;
    localparam logic [CNT_W-1:0] LAT = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] len_q;
    logic [7:0]       shift_q;
    logic             accept;
    logic             in_job;
    logic             last_issue;
    logic             drain_done;

    assign accept     = (state == IDLE) && start;
    assign in_job     = (state == RUN) || (state == DRAIN);
    assign last_issue = (cyc_cnt == len_q - ONE);
    assign drain_done = (cyc_cnt == len_q + LAT + ONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // cyc_cnt is the cycle index since accept; it freezes in RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_cnt     <= '0;
            len_q       <= '0;
            shift_q     <= '0;
            wet_rd_addr <= '0;
            act_rd_addr <= '0;
        end else if (accept) begin
            cyc_cnt     <= '0;
            len_q       <= CNT_W'(cfg_len);
            shift_q     <= cfg_shift;
            wet_rd_addr <= cfg_wet_base;
            act_rd_addr <= cfg_act_base;
        end else begin
            if (in_job) begin
                cyc_cnt <= cyc_cnt + ONE;
            end
            if ((state == RUN) && !last_issue) begin
                wet_rd_addr <= wet_rd_addr + ADDR_W'(1);
                act_rd_addr <= act_rd_addr + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (cfg_len == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (last_issue) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // mac_en spans K+1 cycles: the PE registers the product one edge before accumulating it.
    always_comb begin
        busy         = (state != IDLE);
        wet_rd_en    = (state == RUN);
        act_rd_en    = (state == RUN);
        pe_clear_acc = in_job && (cyc_cnt == LAT - ONE);
        pe_mac_en    = in_job && (cyc_cnt >= LAT) && (cyc_cnt <= len_q + LAT);
        res_valid    = (state == RESP);
        pe_shift_num = (state != IDLE) ? shift_q : 8'd0;
    end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Scoreboard bench for pe_array_ctrl: buffers and a PE lane array are modelled around the
// controller, and every job's timing and final saturated results are checked per cycle.
module tb_pe_array_ctrl;

    localparam int ADDR_W  = 10;
    localparam int LEN_W   = 10;
    localparam int RD_LAT  = 2;
    localparam int MAC_NUM = 4;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int VEC_W   = 6 + 8 + 2 * ADDR_W + 8 * MAC_NUM;

    typedef struct {
        int                   len;
        int                   wb;
        int                   ab;
        int                   sh;
        logic [8*MAC_NUM-1:0] res;
    } job_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic [ADDR_W-1:0] cfg_wet_base = '0;
    logic [ADDR_W-1:0] cfg_act_base = '0;
    logic [7:0]        cfg_shift = '0;
    logic              res_ready = 1'b0;
    logic              busy;
    logic              wet_rd_en;
    logic [ADDR_W-1:0] wet_rd_addr;
    logic              act_rd_en;
    logic [ADDR_W-1:0] act_rd_addr;
    logic              pe_mac_en;
    logic              pe_clear_acc;
    logic [7:0]        pe_shift_num;
    logic              res_valid;

    int   n_vec = 0;
    int   n_err = 0;
    job_t exp_q[$];
    bit   mon_active = 1'b0;
    bit   bp_mode = 1'b0;

    pe_array_ctrl #(
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .cfg_len     (cfg_len),
        .cfg_wet_base(cfg_wet_base),
        .cfg_act_base(cfg_act_base),
        .cfg_shift   (cfg_shift),
        .busy        (busy),
        .wet_rd_en   (wet_rd_en),
        .wet_rd_addr (wet_rd_addr),
        .act_rd_en   (act_rd_en),
        .act_rd_addr (act_rd_addr),
        .pe_mac_en   (pe_mac_en),
        .pe_clear_acc(pe_clear_acc),
        .pe_shift_num(pe_shift_num),
        .res_valid   (res_valid),
        .res_ready   (res_ready)
    );

    always #5 clk = ~clk;

    function automatic logic signed [7:0] sat8(input longint v);
        if (v > 127) return 8'sh7F;
        if (v < -128) return 8'sh80;
        return v[7:0];
    endfunction

    // Buffers with RD_LAT cycles addr->data, and a PE array that registers the product,
    // clears one edge after clear_acc, and latches its output when mac_en falls.
    logic signed [7:0]            wet_mem  [DEPTH];
    logic signed [7:0]            act_mem  [DEPTH][MAC_NUM];
    logic signed [7:0]            wet_pipe [RD_LAT];
    logic signed [7:0]            act_pipe [RD_LAT][MAC_NUM];
    int                           acc      [MAC_NUM];
    int                           prod     [MAC_NUM];
    logic                         clear_q;
    logic                         mac_q;
    logic [MAC_NUM-1:0][7:0]      pe_out;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clear_q <= 1'b0;
            mac_q   <= 1'b0;
            pe_out  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                wet_pipe[i] <= '0;
                for (int l = 0; l < MAC_NUM; l++) act_pipe[i][l] <= '0;
            end
            for (int l = 0; l < MAC_NUM; l++) begin
                acc[l]  <= 0;
                prod[l] <= 0;
            end
        end else begin
            clear_q <= pe_clear_acc;
            mac_q   <= pe_mac_en;
            if (wet_rd_en) wet_pipe[0] <= wet_mem[wet_rd_addr];
            for (int l = 0; l < MAC_NUM; l++) begin
                if (act_rd_en) act_pipe[0][l] <= act_mem[act_rd_addr][l];
            end
            for (int i = 1; i < RD_LAT; i++) begin
                wet_pipe[i] <= wet_pipe[i-1];
                for (int l = 0; l < MAC_NUM; l++) act_pipe[i][l] <= act_pipe[i-1][l];
            end
            for (int l = 0; l < MAC_NUM; l++) begin
                prod[l] <= int'(wet_pipe[RD_LAT-1]) * int'(act_pipe[RD_LAT-1][l]);
                if (clear_q) acc[l] <= 0;
                else if (pe_mac_en) acc[l] <= acc[l] + prod[l];
                if (mac_q && !pe_mac_en) pe_out[l] <= sat8(longint'(acc[l] >>> pe_shift_num));
            end
        end
    end

    function automatic logic [VEC_W-1:0] pack(input logic b, input logic we, input logic ae,
                                              input logic cl, input logic mc, input logic v,
                                              input logic [7:0] sh, input logic [ADDR_W-1:0] wa,
                                              input logic [ADDR_W-1:0] aa,
                                              input logic [8*MAC_NUM-1:0] r);
        return {b, we, ae, cl, mc, v, sh, wa, aa, r};
    endfunction

    function automatic logic [VEC_W-1:0] idleMask();
        return pack(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, '0, '0, '0);
    endfunction

    function automatic logic [VEC_W-1:0] rstMask();
        return pack(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, '1, '1, '0);
    endfunction

    // Expected controller outputs for cycle c of job j, straight from the timing rules.
    task automatic expectCycle(input job_t j, input int c,
                               output logic [VEC_W-1:0] e, output logic [VEC_W-1:0] m);
        bit issue;
        bit done;
        int k_last;
        issue  = (c < j.len);
        done   = (c >= j.len + RD_LAT + 2);
        k_last = issue ? c : j.len - 1;
        e = pack(1'b1, issue, issue, c == RD_LAT - 1, (c >= RD_LAT) && (c <= j.len + RD_LAT),
                 done, j.sh[7:0], ADDR_W'((j.wb + k_last) % DEPTH),
                 ADDR_W'((j.ab + k_last) % DEPTH), done ? j.res : '0);
        m = pack(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF,
                 (j.len > 0) ? {ADDR_W{1'b1}} : {ADDR_W{1'b0}},
                 (j.len > 0) ? {ADDR_W{1'b1}} : {ADDR_W{1'b0}},
                 done ? {8*MAC_NUM{1'b1}} : {8*MAC_NUM{1'b0}});
    endtask

    task automatic checkOutput(input string name, input int c,
                               input logic [VEC_W-1:0] e, input logic [VEC_W-1:0] m);
        logic [VEC_W-1:0] act;
        act = pack(busy, wet_rd_en, act_rd_en, pe_clear_acc, pe_mac_en, res_valid,
                   pe_shift_num, wet_rd_addr, act_rd_addr, pe_out);
        n_vec++;
        if ((act & m) !== (e & m)) begin
            n_err++;
            $display("[TB] FAIL %s cycle %0d: got %h required %h", name, c, act & m, e & m);
        end
    endtask

    task automatic applyStimulus(input int len, input int wb, input int ab, input int sh,
                                 input int gap);
        job_t   j;
        int     guard;
        longint sum;
        guard = 0;
        while (busy && guard < 400) begin
            start        = ($urandom_range(0, 3) == 0);
            cfg_len      = LEN_W'($urandom);
            cfg_wet_base = ADDR_W'($urandom);
            cfg_act_base = ADDR_W'($urandom);
            cfg_shift    = 8'($urandom);
            @(posedge clk); #1;
            guard++;
        end
        if (busy) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL busy_timeout: busy=%b required 0 within 400 cycles", busy);
        end
        start = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        j.len = len;
        j.wb  = wb;
        j.ab  = ab;
        j.sh  = sh;
        j.res = '0;
        for (int l = 0; l < MAC_NUM; l++) begin
            sum = 0;
            for (int k = 0; k < len; k++) begin
                sum += longint'(wet_mem[(wb + k) % DEPTH]) * longint'(act_mem[(ab + k) % DEPTH][l]);
            end
            j.res[l*8 +: 8] = sat8(sum >>> sh);
        end
        exp_q.push_back(j);
        start        = 1'b1;
        cfg_len      = LEN_W'(len);
        cfg_wet_base = ADDR_W'(wb);
        cfg_act_base = ADDR_W'(ab);
        cfg_shift    = 8'(sh);
        @(posedge clk); #1;
        start        = 1'b0;
        cfg_len      = LEN_W'($urandom);
        cfg_wet_base = ADDR_W'($urandom);
        cfg_act_base = ADDR_W'($urandom);
        cfg_shift    = 8'($urandom);
    endtask

    initial begin : ready_driver
        int bp_cnt;
        bp_cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (bp_mode) begin
                bp_cnt    = res_valid ? bp_cnt + 1 : 0;
                res_ready = (bp_cnt >= 6);
            end else begin
                bp_cnt    = 0;
                res_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin : monitor
        job_t             j;
        logic [VEC_W-1:0] e;
        logic [VEC_W-1:0] m;
        int               c;
        int               guard;
        bit               done;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                checkOutput("reset_zero", 0, '0, rstMask());
            end else if (!busy) begin
                checkOutput("idle_quiet", 0, '0, idleMask());
            end else if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("[TB] FAIL spurious_job: busy=%b required 0 (no job issued)", busy);
                guard = 0;
                while (busy && reset_n && guard < 300) begin
                    @(negedge clk);
                    guard++;
                end
            end else begin
                j          = exp_q.pop_front();
                mon_active = 1'b1;
                c          = 0;
                done       = 1'b0;
                while (!done) begin
                    if (!reset_n) begin
                        checkOutput("reset_abort", c, '0, rstMask());
                        done = 1'b1;
                    end else begin
                        expectCycle(j, c, e, m);
                        checkOutput("job_cycle", c, e, m);
                        if ((c >= j.len + RD_LAT + 2) && res_ready) begin
                            @(negedge clk);
                            if (reset_n) checkOutput("post_handshake", c + 1, '0, idleMask());
                            done = 1'b1;
                        end else if (c > j.len + RD_LAT + 300) begin
                            n_vec++;
                            n_err++;
                            $display("[TB] FAIL handshake_timeout: res_valid=%b required handshake by cycle %0d",
                                     res_valid, c);
                            done = 1'b1;
                        end else begin
                            @(negedge clk);
                            c++;
                        end
                    end
                end
                mon_active = 1'b0;
            end
        end
    end

    initial begin : stimulus
        int len;
        int gap;
        int guard;
        for (int i = 0; i < DEPTH; i++) begin
            wet_mem[i] = 8'($urandom);
            for (int l = 0; l < MAC_NUM; l++) act_mem[i][l] = 8'($urandom);
        end
        for (int k = 0; k < 4; k++) begin
            wet_mem['h010 + k] = 8'sd2;
            for (int l = 0; l < MAC_NUM; l++) act_mem['h200 + k][l] = 8'sd3;
        end
        for (int k = 0; k < 8; k++) begin
            wet_mem['h020 + k]    = 8'sh7F;
            act_mem['h220 + k][0] = 8'sh7F;
            act_mem['h220 + k][1] = 8'sh80;
            act_mem['h220 + k][2] = 8'sh04;
            act_mem['h220 + k][3] = 8'shFF;
        end

        #1 reset_n = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b1;

        applyStimulus(4, 'h010, 'h200, 0, 1);
        applyStimulus(8, 'h020, 'h220, 0, 0);
        applyStimulus(1, 'h020, 'h220, 3, 0);
        bp_mode = 1'b1;
        applyStimulus(5, 'h100, 'h300, 2, 0);
        applyStimulus(3, 'h040, 'h240, 1, 0);
        bp_mode = 1'b0;
        applyStimulus(0, 'h050, 'h250, 4, 0);
        applyStimulus(5, 'h3FE, 'h3FC, 1, 0);

        // Abort a K=6 job in its cycle 2, then rerun it from a clean IDLE.
        applyStimulus(6, 'h060, 'h260, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        applyStimulus(6, 'h060, 'h260, 0, 0);

        for (int n = 0; n < 40; n++) begin
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(30, 80)) : int'($urandom_range(0, 12));
            gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            applyStimulus(len, $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
                          $urandom_range(0, 9), gap);
        end

        guard = 0;
        while ((exp_q.size() != 0 || mon_active || busy) && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 2000) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL drain_timeout: %0d jobs outstanding, required 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
